axil_fifo_to_mcl_req: RTL and testbench

- Sits between the host-to-manycore AXI-Lite write-data FIFO and the manycore link request path.
- Collects four consecutive 32-bit host words into one 128-bit bsg_mcl_request_s packet.
- Holds each completed packet until the link accepts it.
- Keeps the host request credit count that feeds the HOST_REQ_CREDITS monitor register.

---
 rtl/axil_fifo_to_mcl_req_pkg.sv | 23 ++
 rtl/axil_fifo_to_mcl_req_credit_counter.sv | 32 +++
 rtl/axil_fifo_to_mcl_req.sv | 82 ++++++++
 tb/tb_axil_fifo_to_mcl_req.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axil_fifo_to_mcl_req_pkg.sv
// Shared manycore-link request definitions used on the host-to-manycore path.
package axil_fifo_to_mcl_req_pkg;

    localparam int mcl_word_width_gp      = 32;
    localparam int mcl_pkt_width_gp       = 128;
    localparam int mcl_words_per_pkt_gp   = mcl_pkt_width_gp / mcl_word_width_gp;
    localparam int mcl_max_credits_gp     = 16;
    localparam int host_req_credits_idx_gp = 'h14;

    // Field order is MSB first, so x_cord lands in bits [7:0] of host word 0.
    typedef struct packed {
        logic [15:0] padding;
        logic [31:0] addr;
        logic [7:0]  op;
        logic [7:0]  op_ex;
        logic [31:0] payload;
        logic [7:0]  src_y_cord;
        logic [7:0]  src_x_cord;
        logic [7:0]  y_cord;
        logic [7:0]  x_cord;
    } bsg_mcl_request_s;

endpackage

// File: rtl/axil_fifo_to_mcl_req_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module mcl_credit_counter #(
    parameter  int max_p   = 16,
    localparam int width_lp = $clog2(max_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o,
    output logic                err_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= width_lp'(max_p);
            err_o   <= 1'b0;
        end else begin
            unique case ({up_i, down_i})
                2'b10: begin
                    if (count_o == width_lp'(max_p)) err_o <= 1'b1;
                    else                             count_o <= count_o + 1'b1;
                end
                2'b01: begin
                    if (count_o != '0) count_o <= count_o - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axil_fifo_to_mcl_req.sv
// Packs four host FIFO words into one manycore link request and tracks request credits.
module axil_fifo_to_mcl_req
    import axil_fifo_to_mcl_req_pkg::*;
#(
    parameter  int word_width_p  = mcl_word_width_gp,
    parameter  int pkt_width_p   = mcl_pkt_width_gp,
    parameter  int max_credits_p = mcl_max_credits_gp,
    localparam int words_lp      = pkt_width_p / word_width_p,
    localparam int cnt_width_lp  = $clog2(words_lp),
    localparam int credit_width_lp = $clog2(max_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [word_width_p-1:0]    data_i,
    output logic                       ready_o,
    output logic                       pkt_v_o,
    output logic [pkt_width_p-1:0]     pkt_o,
    input  logic                       pkt_ready_i,
    input  logic                       credit_return_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       credit_err_o
);

    typedef enum logic {FILL, SEND} state_e;

    state_e                                  state_r, state_n;
    logic [cnt_width_lp-1:0]                 word_cnt_r;
    logic [words_lp-1:0][word_width_p-1:0]   words_r;
    logic                                    accept;
    logic                                    send;
    logic                                    last_word;

    assign accept    = v_i & ready_o;
    assign send      = pkt_v_o & pkt_ready_i;
    assign last_word = (word_cnt_r == cnt_width_lp'(words_lp - 1));
    assign pkt_o     = words_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= FILL;
            word_cnt_r <= '0;
            words_r    <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                words_r[word_cnt_r] <= data_i;
                word_cnt_r          <= last_word ? '0 : word_cnt_r + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        pkt_v_o = 1'b0;
        unique case (state_r)
            FILL: begin
                ready_o = ~reset_i;
                if (accept && last_word) state_n = SEND;
            end
            SEND: begin
                // Valid is gated by credits only, never by the link's ready.
                pkt_v_o = (credits_o != '0);
                if (send) state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

    mcl_credit_counter #(
        .max_p(max_credits_p)
    ) credit_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .up_i   (credit_return_i),
        .down_i (send),
        .count_o(credits_o),
        .err_o  (credit_err_o)
    );

endmodule

// File: tb/tb_axil_fifo_to_mcl_req.sv
// Directed self-checking bench for axil_fifo_to_mcl_req.
module tb_axil_fifo_to_mcl_req;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [31:0]  data_i;
    logic         ready_o;
    logic         pkt_v_o;
    logic [127:0] pkt_o;
    logic         pkt_ready_i;
    logic         credit_return_i;
    logic [4:0]   credits_o;
    logic         credit_err_o;

    int errors = 0;
    int checks = 0;

    axil_fifo_to_mcl_req #(
        .word_width_p (32),
        .pkt_width_p  (128),
        .max_credits_p(16)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .pkt_v_o        (pkt_v_o),
        .pkt_o          (pkt_o),
        .pkt_ready_i    (pkt_ready_i),
        .credit_return_i(credit_return_i),
        .credits_o      (credits_o),
        .credit_err_o   (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        v_i    = 1'b1;
        data_i = d;
        step();
        v_i    = 1'b0;
    endtask

    task automatic feed4(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
        send_word(w0);
        send_word(w1);
        send_word(w2);
        send_word(w3);
    endtask

    logic [127:0] exp_pkt;

    initial begin
        reset_i = 1'b1; v_i = 1'b0; data_i = '0;
        pkt_ready_i = 1'b0; credit_return_i = 1'b0;
        #1;
        chk("ready_in_reset", 128'(ready_o), 128'd0);
        step();
        step();
        chk("rst_credits", 128'(credits_o), 128'd16);
        chk("rst_pkt_v", 128'(pkt_v_o), 128'd0);
        chk("rst_pkt", pkt_o, 128'd0);
        chk("rst_err", 128'(credit_err_o), 128'd0);
        reset_i = 1'b0;
        #1;
        chk("ready_after_rst", 128'(ready_o), 128'd1);

        // Single packet
        pkt_ready_i = 1'b1;
        send_word(32'h0403_0201);
        send_word(32'h0000_0011);
        send_word(32'hAAAA_0002);
        chk("no_v_before_last", 128'(pkt_v_o), 128'd0);
        send_word(32'h0000_1234);
        chk("single_pkt_v", 128'(pkt_v_o), 128'd1);
        chk("single_pkt", pkt_o, 128'h0000_1234_AAAA_0002_0000_0011_0403_0201);
        chk("single_ready_send", 128'(ready_o), 128'd0);
        chk("single_credits_pre", 128'(credits_o), 128'd16);
        step();
        chk("single_pkt_v_drop", 128'(pkt_v_o), 128'd0);
        chk("single_credits", 128'(credits_o), 128'd15);

        // Backpressure
        pkt_ready_i = 1'b0;
        feed4(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004);
        exp_pkt = 128'h4444_0004_3333_0003_2222_0002_1111_0001;
        v_i = 1'b1; data_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            #0;
            chk("bp_ready", 128'(ready_o), 128'd0);
            chk("bp_pkt", pkt_o, exp_pkt);
            step();
        end
        chk("bp_pkt_v", 128'(pkt_v_o), 128'd1);
        chk("bp_credits_hold", 128'(credits_o), 128'd15);
        pkt_ready_i = 1'b1;
        step();
        chk("bp_credits", 128'(credits_o), 128'd14);
        chk("bp_ready_back", 128'(ready_o), 128'd1);
        step();
        v_i = 1'b0;
        send_word(32'h5555_0005);
        send_word(32'h6666_0006);
        send_word(32'h7777_0007);
        chk("bp_next_slot0", pkt_o, 128'h7777_0007_6666_0006_5555_0005_DEAD_BEEF);
        step();
        chk("bp_credits2", 128'(credits_o), 128'd13);

        // Credit exhaustion: 3 sent so far, 13 more reach zero
        for (int p = 0; p < 13; p++) begin
            feed4(32'(p), 32'(p + 1), 32'(p + 2), 32'(p + 3));
            step();
        end
        chk("exh_credits0", 128'(credits_o), 128'd0);
        feed4(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        chk("exh_pkt_v0", 128'(pkt_v_o), 128'd0);
        step();
        step();
        chk("exh_pkt_v0_hold", 128'(pkt_v_o), 128'd0);
        chk("exh_ready_hold", 128'(ready_o), 128'd0);
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        chk("exh_ret_pkt_v", 128'(pkt_v_o), 128'd1);
        chk("exh_ret_credits", 128'(credits_o), 128'd1);
        chk("exh_pkt", pkt_o, 128'hC0DE_0003_C0DE_0002_C0DE_0001_C0DE_0000);
        step();
        chk("exh_after_send", 128'(credits_o), 128'd0);
        chk("exh_after_v", 128'(pkt_v_o), 128'd0);

        // Simultaneous send and return at 5
        credit_return_i = 1'b1;
        repeat (5) step();
        credit_return_i = 1'b0;
        chk("sim_credits_pre", 128'(credits_o), 128'd5);
        feed4(32'h1, 32'h2, 32'h3, 32'h4);
        chk("sim_pkt_v", 128'(pkt_v_o), 128'd1);
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        chk("sim_credits", 128'(credits_o), 128'd5);
        chk("sim_state_fill", 128'(ready_o), 128'd1);

        // Overflow error
        credit_return_i = 1'b1;
        repeat (11) step();
        credit_return_i = 1'b0;
        chk("ovf_credits_max", 128'(credits_o), 128'd16);
        chk("ovf_err_pre", 128'(credit_err_o), 128'd0);
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        chk("ovf_credits_sat", 128'(credits_o), 128'd16);
        chk("ovf_err", 128'(credit_err_o), 128'd1);
        feed4(32'h9, 32'h8, 32'h7, 32'h6);
        step();
        chk("ovf_send_credits", 128'(credits_o), 128'd15);
        chk("ovf_err_sticky", 128'(credit_err_o), 128'd1);

        // Reset mid-packet
        send_word(32'hBAD0_0000);
        send_word(32'hBAD0_0001);
        reset_i = 1'b1;
        #1;
        chk("mid_ready_rst", 128'(ready_o), 128'd0);
        step();
        reset_i = 1'b0;
        chk("mid_credits", 128'(credits_o), 128'd16);
        chk("mid_err_clr", 128'(credit_err_o), 128'd0);
        chk("mid_pkt_clr", pkt_o, 128'd0);
        feed4(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
        chk("mid_pkt_v", 128'(pkt_v_o), 128'd1);
        chk("mid_pkt", pkt_o, 128'hA000_0003_A000_0002_A000_0001_A000_0000);
        step();
        chk("mid_credits_after", 128'(credits_o), 128'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
